multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Multicycle MIPS control unit, the successor to the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and drives datapath enables per state. It supports an optional memory-ready handshake and counts retired instructions. It sits between the instruction register opcode/funct fields and the multicycle datapath (PC, IR, register file, ALU, unified memory).

Parameters:
ALUOP_W, 3, ALU op width; codes zero-extended when wider than 3
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: memory states last exactly one cycle
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  6  instruction[31:26] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete (ignored when MEM_HANDSHAKE=0)
pc_en  out  1  PC load = pc_write | (branch_eq & zero) | (branch_ne & ~zero)
i_or_d  out  1  memory address source: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_dst  out  2  write register: 0=rt, 1=rd, 2=$31
mem_to_reg  out  2  write data: 0=ALUOut, 1=MDR, 2=PC (link)
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=const 4, 2=ext imm, 3=ext imm<<2
zero_imm  out  1  zero-extend immediate (ANDI/ORI)
lui  out  1  LUI path select
pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
alu_op  out  ALUOP_W  AND=0, OR=1, NOR=2, ADD=3, SUB=4, LUI=5, JAL=6, FUNCT=7
state_o  out  4  current state encoding (debug)
illegal_op  out  1  one-cycle registered pulse on an unsupported opcode
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, reset=0): state=FETCH, instr_count=0, illegal_op=0. Because outputs decode from state, the reset values are: mem_read=1, alu_src_b=1, alu_op=ADD(3); all other outputs 0. pc_en=0 while mem_ready=0 and MEM_HANDSHAKE=1.
- Outputs are a combinational decode of the state register (Moore), except pc_en and the FETCH ir_write, which also depend on zero/mem_ready.
- Encodings for op: R=00, J=02, JAL=03, BEQ=04, BNE=05, ADDI=08, ANDI=0C, ORI=0D, LUI=0F, LW=23, SW=2B.
- FETCH(0): mem_read, i_or_d=0, alu_src_a=0, alu_src_b=1, ADD. ir_write and pc_write are asserted only in the completing cycle (mem_ready=1, or always when MEM_HANDSHAKE=0), which then moves to DECODE. Otherwise FETCH holds.
- DECODE(1): alu_src_a=0, alu_src_b=3, ADD (branch target precompute). Next state by op: LW/SW->MEM_ADDR; R->R_EXEC; ADDI/ANDI/ORI/LUI->I_EXEC; BEQ/BNE->BRANCH; J->JUMP; JAL->JAL_WB. Any other op -> FETCH with illegal_op=1 the next cycle; not counted as retired.
- MEM_ADDR(2): alu_src_a=1, alu_src_b=2, ADD; LW->MEM_RD, SW->MEM_WR.
- MEM_RD(3): mem_read, i_or_d=1; waits for mem_ready like FETCH, then ->MEM_WB.
- MEM_WB(4): reg_write, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR(5): mem_write, i_or_d=1; mem_write is held until the completing cycle -> FETCH.
- R_EXEC(6): alu_src_a=1, alu_src_b=0, FUNCT -> R_WB(7): reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
- I_EXEC(8): alu_src_a=1, alu_src_b=2. Per op: ADDI=ADD; ANDI=AND with zero_imm; ORI=OR with zero_imm; LUI=LUI with lui=1. ->I_WB(9): reg_write, reg_dst=0, with zero_imm/lui held -> FETCH.
- BRANCH(10): alu_src_a=1, alu_src_b=0, SUB, pc_source=1. branch_eq for BEQ, branch_ne for BNE. pc_en resolves from zero in the same cycle -> FETCH.
- JUMP(11): pc_write, pc_source=2 -> FETCH.
- JAL_WB(12): reg_write, reg_dst=2, mem_to_reg=2, pc_write, pc_source=2, alu_op=JAL -> FETCH.
- Unused encodings 13-15 -> FETCH next cycle.
- op is sampled in DECODE, MEM_ADDR and I_EXEC; IR is stable outside FETCH.
- instr_count increments on the cycle a terminal state (MEM_WB, MEM_WR-complete, R_WB, I_WB, BRANCH, JUMP, JAL_WB) transitions to FETCH. It wraps from all-ones to 0.
- Async reset mid-instruction aborts immediately, including during a pending memory wait. No write strobe is asserted after reset asserts.

Decomposition:
- Package mips_ctrl_pkg: opcode localparams, ALU op codes, the state enum (4-bit), and alu_src_b/pc_source/reg_dst/mem_to_reg select codes.
- One sub-module: multicycle_ctrl_decode, a combinational state+op -> control-vector decode. The top level keeps the state register, next-state logic, counter and illegal pulse.

Test Plan:
- Reset with MEM_HANDSHAKE=1, mem_ready=0 for 3 cycles -> state_o=0, mem_read=1, ir_write=0, pc_en=0, instr_count=0; mem_ready=1 -> ir_write=1, pc_en=1, next state_o=1.
- LW (op=23), mem_ready=1 throughout -> states 0,1,2,3,4,0 over 5 cycles; MEM_WB has reg_write=1, mem_to_reg=1; instr_count 0->1.
- BEQ with zero=1 then BNE with zero=1 -> pc_en=1 in BRANCH for BEQ, pc_en=0 for BNE; alu_op=4 both times.
- ORI (0D) -> I_EXEC/I_WB with zero_imm=1, alu_op=1; LUI (0F) -> lui=1, alu_op=5; JAL (03) -> reg_dst=2, mem_to_reg=2, pc_source=2.
- op=3F in DECODE -> next state FETCH, illegal_op=1 for exactly one cycle, instr_count unchanged.
- CNT_W=4: retire 16 R-type ops -> instr_count wraps to 0. Assert reset during MEM_RD wait -> state_o=0 immediately and no mem_write pulse.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU codes, FSM states and datapath select codes for the multicycle MIPS control.
// Latency: n/a (definitions only); backpressure: n/a.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [2:0] ALU_AND   = 3'd0;
    localparam logic [2:0] ALU_OR    = 3'd1;
    localparam logic [2:0] ALU_NOR   = 3'd2;
    localparam logic [2:0] ALU_ADD   = 3'd3;
    localparam logic [2:0] ALU_SUB   = 3'd4;
    localparam logic [2:0] ALU_LUI   = 3'd5;
    localparam logic [2:0] ALU_JAL   = 3'd6;
    localparam logic [2:0] ALU_FUNCT = 3'd7;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL_WB   = 4'd12
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state+opcode -> datapath control vector for the multicycle MIPS FSM.
// Latency: zero cycles (pure decode); backpressure: memDone gates the FETCH IR/PC load.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memDone,
    output logic       pcEn,
    output logic       iOrD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       zeroImm,
    output logic       lui,
    output logic [1:0] pcSource,
    output logic [2:0] aluOp
);

    logic       pcWrite;
    logic       branchEq;
    logic       branchNe;
    logic [2:0] immAluOp;
    logic       immZero;
    logic       immLui;

    // Immediate-op flavour is held across I_EXEC and I_WB so the ALU result stays stable.
    always_comb begin
        immAluOp = ALU_ADD;
        immZero  = 1'b0;
        immLui   = 1'b0;
        case (op)
            OP_ANDI: begin immAluOp = ALU_AND; immZero = 1'b1; end
            OP_ORI:  begin immAluOp = ALU_OR;  immZero = 1'b1; end
            OP_LUI:  begin immAluOp = ALU_LUI; immLui  = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        pcWrite  = 1'b0;
        branchEq = 1'b0;
        branchNe = 1'b0;
        iOrD     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        irWrite  = 1'b0;
        regDst   = REGDST_RT;
        memToReg = WD_ALUOUT;
        regWrite = 1'b0;
        aluSrcA  = 1'b0;
        aluSrcB  = SRCB_B;
        zeroImm  = 1'b0;
        lui      = 1'b0;
        pcSource = PCSRC_ALU;
        aluOp    = ALU_ADD;
        case (state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                irWrite = memDone;
                pcWrite = memDone;
            end
            S_DECODE:   aluSrcB = SRCB_IMM_SH;
            S_MEM_ADDR: begin aluSrcA = 1'b1; aluSrcB = SRCB_IMM; end
            S_MEM_RD:   begin memRead = 1'b1; iOrD = 1'b1; end
            S_MEM_WB:   begin regWrite = 1'b1; memToReg = WD_MDR; end
            S_MEM_WR:   begin memWrite = 1'b1; iOrD = 1'b1; end
            S_R_EXEC:   begin aluSrcA = 1'b1; aluOp = ALU_FUNCT; end
            S_R_WB:     begin regWrite = 1'b1; regDst = REGDST_RD; end
            S_I_EXEC, S_I_WB: begin
                aluSrcA  = 1'b1;
                aluSrcB  = SRCB_IMM;
                aluOp    = immAluOp;
                zeroImm  = immZero;
                lui      = immLui;
                regWrite = (state == S_I_WB);
            end
            S_BRANCH: begin
                aluSrcA  = 1'b1;
                aluOp    = ALU_SUB;
                pcSource = PCSRC_ALUOUT;
                branchEq = (op == OP_BEQ);
                branchNe = (op == OP_BNE);
            end
            S_JUMP: begin pcWrite = 1'b1; pcSource = PCSRC_JUMP; end
            S_JAL_WB: begin
                regWrite = 1'b1;
                regDst   = REGDST_RA;
                memToReg = WD_PC;
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
                aluOp    = ALU_JAL;
            end
            default: ;
        endcase
    end

    assign pcEn = pcWrite | (branchEq & zero) | (branchNe & ~zero);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, sequencing, retired-instruction counter, illegal-op pulse.
// Latency: one state per cycle; memory states stall on mem_ready when MEM_HANDSHAKE=1.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W       = 3,
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               zero_imm,
    output logic               lui,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state_o,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count
);

    state_t           state;
    state_t           nextState;
    logic             memDone;
    logic             retire;
    logic             illegalNext;
    logic             illegalQ;
    logic [CNT_W-1:0] instrCount;
    logic [2:0]       aluOp3;

    assign memDone = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_comb begin
        nextState   = state;
        retire      = 1'b0;
        illegalNext = 1'b0;
        case (state)
            S_FETCH:  if (memDone) nextState = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:                     nextState = S_MEM_ADDR;
                    OP_R:                             nextState = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nextState = S_I_EXEC;
                    OP_BEQ, OP_BNE:                   nextState = S_BRANCH;
                    OP_J:                             nextState = S_JUMP;
                    OP_JAL:                           nextState = S_JAL_WB;
                    default: begin
                        nextState   = S_FETCH;
                        illegalNext = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: nextState = (op == OP_SW) ? S_MEM_WR :
                                    (op == OP_LW) ? S_MEM_RD : S_FETCH;
            S_MEM_RD:   if (memDone) nextState = S_MEM_WB;
            S_MEM_WR: begin
                if (memDone) begin
                    nextState = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_R_EXEC:   nextState = S_R_WB;
            S_I_EXEC:   nextState = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL_WB: begin
                nextState = S_FETCH;
                retire    = 1'b1;
            end
            default:    nextState = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            instrCount <= '0;
            illegalQ   <= 1'b0;
        end else begin
            state    <= nextState;
            illegalQ <= illegalNext;
            if (retire) instrCount <= instrCount + 1'b1;
        end
    end

    multicycle_ctrl_decode u_decode (
        .state    (state),
        .op       (op),
        .zero     (zero),
        .memDone  (memDone),
        .pcEn     (pc_en),
        .iOrD     (i_or_d),
        .memRead  (mem_read),
        .memWrite (mem_write),
        .irWrite  (ir_write),
        .regDst   (reg_dst),
        .memToReg (mem_to_reg),
        .regWrite (reg_write),
        .aluSrcA  (alu_src_a),
        .aluSrcB  (alu_src_b),
        .zeroImm  (zero_imm),
        .lui      (lui),
        .pcSource (pc_source),
        .aluOp    (aluOp3)
    );

    assign alu_op      = ALUOP_W'(aluOp3);
    assign state_o     = state;
    assign illegal_op  = illegalQ;
    assign instr_count = instrCount;

endmodule
